// File: rtl/div_4.sv
// div_4: sequential restoring divider, one quotient bit per clock, init/done handshake.
// Optional DIV_BUSY_EN adds a busy output and queues a start request seen while busy.
module div_4 #(
    parameter int WN = 8,
    parameter int WD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic [WN-1:0] A,
    input  logic [WD-1:0] B,
    output logic [WN-1:0] q,
    output logic [WD-1:0] r,
    output logic          done,
    output logic          dbz
`ifdef DIV_BUSY_EN
    ,
    output logic          busy
`endif
);
    localparam int CW = $clog2(WN + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic init_d, arm, start, go, ge;
    logic [CW-1:0] cnt;
    logic [WD:0] pr, pr_sh, pr_nx;
    logic [WN-1:0] dvd, quo, quo_nx;
    logic [WD-1:0] bsr;
`ifdef DIV_BUSY_EN
    logic pend;
    assign busy = state != IDLE;
    assign go = start | pend;
`else
    assign go = start;
`endif
    // arm blocks a start on the very first edge after reset, when init has no prior sample
    assign start = init & ~init_d & arm;
    assign done = state == DONE;
    always_comb begin
        pr_sh = {pr[WD-1:0], dvd[WN-1]};
        ge = pr_sh >= {1'b0, bsr};
        pr_nx = ge ? pr_sh - {1'b0, bsr} : pr_sh;
        quo_nx = {quo[WN-2:0], ge};
        state_nx = state;
        case (state)
            IDLE: if (go) state_nx = (B == '0) ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_d <= 1'b0;
            arm <= 1'b0;
            cnt <= '0;
            pr <= '0;
            dvd <= '0;
            quo <= '0;
            bsr <= '0;
            q <= '0;
            r <= '0;
            dbz <= 1'b0;
`ifdef DIV_BUSY_EN
            pend <= 1'b0;
`endif
        end else begin
            init_d <= init;
            arm <= 1'b1;
`ifdef DIV_BUSY_EN
            pend <= (state == IDLE) ? 1'b0 : pend | start;
`endif
            if (state == IDLE && go) begin
                dbz <= B == '0;
                if (B == '0) begin
                    q <= '1;
                    r <= '0;
                end else begin
                    dvd <= A;
                    bsr <= B;
                    pr <= '0;
                    quo <= '0;
                    cnt <= CW'(WN);
                end
            end
            if (state == CALC) begin
                pr <= pr_nx;
                dvd <= {dvd[WN-2:0], 1'b0};
                quo <= quo_nx;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    q <= quo_nx;
                    r <= pr_nx[WD-1:0];
                end
            end
        end
    end
endmodule
